// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// One transaction in flight: IDLE (grant) -> ACCESS (strobe) -> DONE (ack).
module dmem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] readAddress,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q;
  logic                id_q, we_q, last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata0_q, rdata1_q;
  logic                rd_q, wr_q, ack0_q, ack1_q;
  logic                gnt_d;

  // Tie goes to the port not served last; otherwise whoever is asking.
  always_comb begin
    gnt_d = 1'b0;
    if (req0 && req1) gnt_d = ~last_q;
    else if (req1)    gnt_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_q   <= 1'b1;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: if (req0 || req1) begin
          id_q    <= gnt_d;
          we_q    <= gnt_d ? we1    : we0;
          addr_q  <= gnt_d ? addr1  : addr0;
          wdata_q <= gnt_d ? wdata1 : wdata0;
          wr_q    <= gnt_d ? we1    : we0;
          rd_q    <= gnt_d ? ~we1   : ~we0;
          state_q <= ACCESS;
        end
        ACCESS: state_q <= DONE;
        DONE: begin
          if (!we_q) begin
            if (id_q) rdata1_q <= readData;
            else      rdata0_q <= readData;
          end
          ack0_q  <= ~id_q;
          ack1_q  <= id_q;
          last_q  <= id_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are gated by rst_n so an aborted ACCESS never reaches the memory
  // at the reset edge itself.
  assign MemRead      = rd_q & rst_n;
  assign MemWrite     = wr_q & rst_n;
  assign readAddress  = addr_q;
  assign writeAddress = addr_q;
  assign writeData    = wdata_q;
  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, word address width of the data memory.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req0  input  1  port 0 (CPU load/store) request; held high until ack0.
REQ-006 we0  input  1  port 0 access type: 1 = write, 0 = read.
REQ-007 addr0  input  ADDR_W  port 0 word address.
REQ-008 wdata0  input  DATA_W  port 0 write data.
REQ-009 ack0  output  1  port 0 completion pulse, one cycle.
REQ-010 rdata0  output  DATA_W  port 0 read data; valid with ack0 on reads.
REQ-011 req1, we1, addr1, wdata1, ack1, rdata1 SHALL mirror REQ-005..REQ-010 for port 1 (DMA/loader).
REQ-012 MemRead  output  1  read strobe to data memory.
REQ-013 MemWrite  output  1  write strobe to data memory.
REQ-014 readAddress, writeAddress  output  ADDR_W  memory addresses.
REQ-015 writeData  output  DATA_W  memory write data.
REQ-016 readData  input  DATA_W  memory read data, combinational from readAddress.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states IDLE, ACCESS, DONE; exactly one transaction in flight.
REQ-019 IDLE: no req -> stay IDLE; any req -> select winner, latch winner id, we, addr, wdata into holding registers, go ACCESS.
REQ-020 Arbitration round-robin: both requesting -> grant the port not granted last; one requesting -> grant that port.
REQ-021 ACCESS (exactly one cycle): drive MemWrite = latched we, MemRead = not latched we; readAddress and writeAddress = latched addr; writeData = latched wdata; go DONE.
REQ-022 DONE: on reads, capture readData into rdata of the latched port; pulse that port's ack for one cycle; set last-granted = latched id; go IDLE.
REQ-023 MemRead and MemWrite SHALL be 0 in IDLE and DONE; never both 1 in any cycle.
REQ-024 Address and data outputs SHALL hold latched values outside ACCESS; they change only on a new grant.
REQ-025 Latency: req sampled high in IDLE at edge N -> ack at the cycle after edge N+2 (ack high during cycle N+2..N+3); throughput one transaction per 3 cycles.
REQ-026 rdata of a port SHALL change only on that port's read ack; write acks leave it unchanged.
REQ-027 Non-granted port's ack SHALL stay 0; its request stays pending and is served next.
REQ-028 req dropped after grant: latched transaction SHALL still complete and ack.
REQ-029 Requester changing addr/wdata/we after grant: no effect on the in-flight transaction.
REQ-030 Port holding req high through ack SHALL be treated as a new request in the following IDLE cycle.
REQ-031 Full address range 0..2^ADDR_W-1 is legal; no wrap or range check.

Reset
REQ-032 rst_n low at a rising edge SHALL force state IDLE, ack0 = ack1 = 0, rdata0 = rdata1 = 0, MemRead = MemWrite = 0, holding registers 0, last-granted = port 1 (port 0 wins first tie).
REQ-033 Reset during ACCESS SHALL abort the transaction: no ack; MemWrite low from the reset edge onward.
REQ-034 Outputs SHALL remain at reset values while rst_n is low, regardless of requests.

Verification
REQ-035 Reset then req0 write addr 0x005, data 0xDEADBEEF -> MemWrite=1, writeAddress=0x005 for one cycle; ack0 two cycles later; rdata0 stays 0.
REQ-036 Following req0 read addr 0x005 -> MemRead=1, readAddress=0x005; ack0 with rdata0=0xDEADBEEF.
REQ-037 req0 and req1 asserted together from reset, held -> grants alternate 0,1,0,1; each ack every 3 cycles; acks never coincide.
REQ-038 req1 write 0x1FF <- 0x12345678 then req1 read 0x1FF -> rdata1=0x12345678; rdata0 unchanged.
REQ-039 rst_n low during ACCESS of a write -> no ack; busy=0 after reset; subsequent read of that address returns prior contents.
REQ-040 req0 pulsed one cycle then dropped -> transaction completes, single ack0, state returns IDLE with busy=0.
